// File: rtl/cart_sram_arbiter_if.sv
// Loader, cartridge and SRAM signals of the cart SRAM arbiter, bundled as one interface.
// The slave modport is the arbiter's view; the master modport is the side that drives it.
interface cart_sram_arbiter_if;
  logic        ld_wr;
  logic [18:0] ld_addr;
  logic [7:0]  ld_data;
  logic        ld_ready;
  logic        ovf;
  logic        cart_rd;
  logic [18:0] cart_a;
  logic [7:0]  cart_d;
  logic        cart_valid;
  logic [18:0] sram_a;
  logic        sram_we_n;
  logic [7:0]  sram_dq_o;
  logic        sram_dq_oe;
  logic [7:0]  sram_dq_i;
  logic        busy;

  modport slave (
    input  ld_wr, ld_addr, ld_data, cart_rd, cart_a, sram_dq_i,
    output ld_ready, ovf, cart_d, cart_valid, sram_a, sram_we_n, sram_dq_o, sram_dq_oe, busy
  );

  modport master (
    output ld_wr, ld_addr, ld_data, cart_rd, cart_a, sram_dq_i,
    input  ld_ready, ovf, cart_d, cart_valid, sram_a, sram_we_n, sram_dq_o, sram_dq_oe, busy
  );
endinterface

// File: rtl/cart_sram_arbiter.sv
// Shares one async SRAM between a byte loader (2-deep write FIFO) and cartridge reads,
// alternating between the two when both are waiting.
module cart_sram_arbiter #(
  parameter int RD_WAIT  = 2,
  parameter int WR_PULSE = 2
) (
  input  logic                      clk_sys,
  input  logic                      reset,
  cart_sram_arbiter_if.slave        bus,
  output logic [2:0]                dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR_SETUP = 3'd1,
    S_WR_PULSE = 3'd2,
    S_WR_HOLD  = 3'd3,
    S_RD       = 3'd4
  } state_t;

  state_t      state;
  logic [2:0]  cnt;
  logic [26:0] fifo_mem [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;
  logic        pend_valid;
  logic [18:0] pend_addr;
  logic        last_grant_rd;
  logic [18:0] sram_a_q;
  logic        we_n_q;
  logic        oe_q;
  logic [7:0]  dq_o_q;
  logic [7:0]  cart_d_q;
  logic        cart_valid_q;
  logic        ovf_q;

  logic        full;
  logic        empty;
  logic        pop;
  logic        push_ok;
  logic        rd_req;
  logic [18:0] rd_addr;
  logic        grant_wr;
  logic        grant_rd;
  logic [26:0] head;

  // Handshake: ld_wr is a one-cycle strobe; the byte is taken when the FIFO is not full,
  // or when it is full but the head retires in the same cycle. Otherwise it is lost and ovf sticks.
  always_comb begin
    full     = (count == 2'd2);
    empty    = (count == 2'd0);
    pop      = (state == S_WR_HOLD);
    push_ok  = bus.ld_wr && (!full || pop);
    rd_req   = pend_valid || bus.cart_rd;
    rd_addr  = bus.cart_rd ? bus.cart_a : pend_addr;
    grant_wr = (state == S_IDLE) && !empty && (!rd_req || last_grant_rd);
    grant_rd = (state == S_IDLE) && rd_req && (empty || !last_grant_rd);
    head     = fifo_mem[rd_ptr];
  end

  always_ff @(posedge clk_sys) begin
    if (push_ok && !reset) fifo_mem[wr_ptr] <= {bus.ld_addr, bus.ld_data};
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state         <= S_IDLE;
      cnt           <= 3'd0;
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      count         <= 2'd0;
      pend_valid    <= 1'b0;
      pend_addr     <= 19'd0;
      last_grant_rd <= 1'b1;
      sram_a_q      <= 19'd0;
      we_n_q        <= 1'b1;
      oe_q          <= 1'b0;
      dq_o_q        <= 8'd0;
      cart_d_q      <= 8'd0;
      cart_valid_q  <= 1'b0;
      ovf_q         <= 1'b0;
    end else begin
      cart_valid_q <= 1'b0;
      if (push_ok) wr_ptr <= ~wr_ptr;
      if (pop)     rd_ptr <= ~rd_ptr;
      count <= count + 2'(push_ok) - 2'(pop);
      if (bus.ld_wr && !push_ok) ovf_q <= 1'b1;

      // A read granted straight from IDLE consumes the request; otherwise the newest address waits.
      if (grant_rd) begin
        pend_valid <= 1'b0;
      end else if (bus.cart_rd) begin
        pend_valid <= 1'b1;
        pend_addr  <= bus.cart_a;
      end

      case (state)
        S_IDLE: begin
          if (grant_wr) begin
            state         <= S_WR_SETUP;
            sram_a_q      <= head[26:8];
            dq_o_q        <= head[7:0];
            oe_q          <= 1'b1;
            we_n_q        <= 1'b1;
            last_grant_rd <= 1'b0;
          end else if (grant_rd) begin
            state         <= S_RD;
            sram_a_q      <= rd_addr;
            oe_q          <= 1'b0;
            cnt           <= 3'(RD_WAIT - 1);
            last_grant_rd <= 1'b1;
          end
        end
        S_WR_SETUP: begin
          state  <= S_WR_PULSE;
          we_n_q <= 1'b0;
          cnt    <= 3'(WR_PULSE - 1);
        end
        S_WR_PULSE: begin
          if (cnt == 3'd0) begin
            state  <= S_WR_HOLD;
            we_n_q <= 1'b1;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        S_WR_HOLD: begin
          state <= S_IDLE;
          oe_q  <= 1'b0;
        end
        S_RD: begin
          if (cnt == 3'd0) begin
            state        <= S_IDLE;
            cart_d_q     <= bus.sram_dq_i;
            cart_valid_q <= 1'b1;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        default: begin
          state  <= S_IDLE;
          we_n_q <= 1'b1;
          oe_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ld_ready   = !full;
  assign bus.ovf        = ovf_q;
  assign bus.cart_d     = cart_d_q;
  assign bus.cart_valid = cart_valid_q;
  assign bus.sram_a     = sram_a_q;
  assign bus.sram_we_n  = we_n_q;
  assign bus.sram_dq_o  = dq_o_q;
  assign bus.sram_dq_oe = oe_q;
  assign bus.busy       = (state != S_IDLE) || !empty || pend_valid;
  assign dbg_state      = state;

endmodule

// File: doc/cart_sram_arbiter.md
CART_SRAM_ARBITER -- requirements
Module: cart_sram_arbiter

Interface
REQ-001 Parameter RD_WAIT, default 2: number of cycles an SRAM read address is held before data is sampled (1..7).
REQ-002 Parameter WR_PULSE, default 2: number of cycles sram_we_n is held low per write (1..7).
REQ-003 clk_sys  in  1  system clock; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 ld_wr  in  1  loader write strobe, one cycle per byte.
REQ-006 ld_addr  in  19  loader byte address.
REQ-007 ld_data  in  8  loader byte data.
REQ-008 ld_ready  out  1  write FIFO not full.
REQ-009 ovf  out  1  sticky flag: a loader byte was dropped.
REQ-010 cart_rd  in  1  cartridge read request strobe.
REQ-011 cart_a  in  19  cartridge read address, sampled with cart_rd.
REQ-012 cart_d  out  8  last cartridge read data, held until the next completion.
REQ-013 cart_valid  out  1  one-cycle pulse when cart_d is updated.
REQ-014 sram_a  out  19  SRAM address, registered.
REQ-015 sram_we_n  out  1  SRAM write enable, active low, registered.
REQ-016 sram_dq_o  out  8  SRAM write data.
REQ-017 sram_dq_oe  out  1  drive enable for the SRAM data bus.
REQ-018 sram_dq_i  in  8  SRAM read data.
REQ-019 busy  out  1  high while the state is not IDLE, the FIFO is non-empty, or a read is pending.

Function
REQ-020 The write FIFO SHALL hold 2 entries of {addr, data}; ld_ready = not full.
REQ-021 An ld_wr while the FIFO is full and not popping in the same cycle SHALL drop the byte and set ovf; a push and a pop in the same cycle while full SHALL both be accepted.
REQ-022 A cart_rd SHALL latch cart_a into a single pending-read register; a cart_rd arriving while a read is pending SHALL overwrite the address, and only one cart_valid SHALL result.
REQ-023 The states SHALL be IDLE, WR_SETUP, WR_PULSE, WR_HOLD and RD.
REQ-024 IDLE arbitration: only the FIFO non-empty -> WR_SETUP; only a read pending -> RD; both -> the requester not granted last (last_grant toggle).
REQ-025 WR_SETUP (1 cycle): sram_a = FIFO head addr, sram_dq_o = head data, sram_dq_oe = 1, sram_we_n = 1.
REQ-026 WR_PULSE (WR_PULSE cycles): sram_we_n = 0; address and data stable.
REQ-027 WR_HOLD (1 cycle): sram_we_n = 1, sram_dq_oe = 1; FIFO pop; then IDLE. A write therefore occupies WR_PULSE+2 cycles (4 by default).
REQ-028 RD (RD_WAIT cycles): sram_a = pending address, sram_dq_oe = 0, sram_we_n = 1.
REQ-029 sram_dq_i SHALL be sampled into cart_d at the end of the last RD cycle; cart_valid pulses in the following cycle, which is IDLE; the pending read is then cleared.
REQ-030 Read latency, FIFO empty and state IDLE: cart_rd in cycle 0 -> cart_valid in cycle RD_WAIT+1 (cycle 3 by default).
REQ-031 A cart_rd arriving during RD SHALL become a new pending read, serviced after the current one completes.
REQ-032 sram_we_n SHALL never be low unless sram_dq_oe = 1 and sram_a has been stable for at least one cycle.
REQ-033 sram_dq_oe SHALL be 0 in IDLE and in RD; no bus contention.
REQ-034 sram_a SHALL hold its last value in IDLE.
REQ-035 A counter of 3 bits SHALL time WR_PULSE and RD; it is reloaded on entry to either state.

Reset
REQ-036 On reset: state = IDLE, FIFO empty, pending read cleared, last_grant = read (so a write wins the first tie), sram_we_n = 1, sram_dq_oe = 0, sram_a = 0, sram_dq_o = 0, cart_d = 0, cart_valid = 0, ovf = 0, ld_ready = 1, busy = 0.
REQ-037 Reset asserted mid-write SHALL force sram_we_n = 1 and sram_dq_oe = 0 in the next cycle; the transaction is abandoned.
REQ-038 Reset SHALL take priority over a simultaneous ld_wr or cart_rd; both are ignored.

Verification
REQ-039 Single read: RD_WAIT = 2, sram_dq_i = 0xA5, cart_rd with cart_a = 0x00123 in cycle 0 -> sram_a = 0x00123 in cycles 1-2, cart_valid = 1 and cart_d = 0xA5 in cycle 3.
REQ-040 Single write: ld_wr with addr 0x04000 and data 0x3C -> sram_we_n low for exactly 2 cycles with sram_a = 0x04000, sram_dq_o = 0x3C and sram_dq_oe = 1 throughout; ld_ready remains 1.
REQ-041 Overflow: 3 ld_wr strobes on consecutive cycles from IDLE -> first 2 accepted, third dropped, ovf = 1 and stays 1 until reset.
REQ-042 Contention: FIFO holding 2 bytes and a read pending in IDLE -> order is write, read, write; cart_valid occurs between the two write pulses.
REQ-043 Reset mid-operation: reset in the first WR_PULSE cycle -> next cycle sram_we_n = 1, sram_dq_oe = 0, busy = 0, ld_ready = 1.
